// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: ID-stage request bus and fetch-PC results shared by the PC sequencer and its client.
interface pc_sequencer_if #(
  parameter int SIZE_ADDR_PC = 32,
  parameter int SIZE_CNT     = 16
);
  logic                    i_stall;
  logic                    i_halt;
  logic                    i_is_jump;
  logic                    i_is_JALR;
  logic                    i_pc_source;
  logic [SIZE_ADDR_PC-1:0] i_rs;
  logic [SIZE_ADDR_PC-1:0] i_suma_branch;
  logic [SIZE_ADDR_PC-1:0] i_suma_jump;
  logic [SIZE_ADDR_PC-1:0] o_pc;
  logic [SIZE_ADDR_PC-1:0] o_pc4;
  logic                    o_flush;
  logic                    o_halted;
  logic [SIZE_CNT-1:0]     o_redirect_cnt;
  modport slave (
    input  i_stall, i_halt, i_is_jump, i_is_JALR, i_pc_source, i_rs, i_suma_branch, i_suma_jump,
    output o_pc, o_pc4, o_flush, o_halted, o_redirect_cnt
  );
  modport master (
    output i_stall, i_halt, i_is_jump, i_is_JALR, i_pc_source, i_rs, i_suma_branch, i_suma_jump,
    input  o_pc, o_pc4, o_flush, o_halted, o_redirect_cnt
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch PC register with next-PC selection, redirect flush, and halt drain.
// Optional PC_STEP_MODE_EN adds i_step, gating RUN-state progress to single-step edges.
module pc_sequencer #(
  parameter int                    SIZE_ADDR_PC = 32,
  parameter logic [SIZE_ADDR_PC-1:0] RESET_PC   = '0,
  parameter int                    N_DRAIN      = 3,
  parameter int                    SIZE_CNT     = 16
) (
  input logic i_clk,
  input logic i_reset,
  input logic i_enable,
`ifdef PC_STEP_MODE_EN
  input logic i_step,
`endif
  pc_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, HALTED} state_t;
  localparam logic [3:0] DRAIN_INIT = 4'(N_DRAIN - 1);
  state_t                  state_q, state_d;
  logic [SIZE_ADDR_PC-1:0] pc_q, pc_d, target;
  logic [SIZE_CNT-1:0]     cnt_q, cnt_d;
  logic [3:0]              drain_q, drain_d;
  logic                    flush_q, flush_d, halted_q, halted_d, act, go, redirect;
`ifdef PC_STEP_MODE_EN
  assign act = i_enable & i_step;
`else
  assign act = i_enable;
`endif
  assign go = state_q == RUN && act && !bus.i_stall;
  assign redirect = go && !bus.i_halt && (bus.i_is_JALR || bus.i_is_jump || bus.i_pc_source);
  assign target = bus.i_is_JALR ? bus.i_rs : bus.i_is_jump ? bus.i_suma_jump : bus.i_suma_branch;
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    drain_d  = drain_q;
    halted_d = halted_q;
    flush_d  = redirect;
    case (state_q)
      IDLE: state_d = i_enable ? RUN : IDLE;
      RUN: begin
        if (go && bus.i_halt) begin
          state_d = DRAIN;
          drain_d = DRAIN_INIT;
        end else if (redirect) begin
          pc_d  = target & ~SIZE_ADDR_PC'(3);
          cnt_d = &cnt_q ? cnt_q : cnt_q + SIZE_CNT'(1);
        end else if (go) begin
          pc_d = pc_q + SIZE_ADDR_PC'(4);
        end
      end
      DRAIN: begin
        state_d  = drain_q == 4'd0 ? HALTED : DRAIN;
        halted_d = drain_q == 4'd0;
        drain_d  = drain_q == 4'd0 ? drain_q : drain_q - 4'd1;
      end
      default: ;
    endcase
  end
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      cnt_q    <= '0;
      drain_q  <= '0;
      flush_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      drain_q  <= drain_d;
      flush_q  <= flush_d;
      halted_q <= halted_d;
    end
  end
  assign bus.o_pc           = pc_q;
  assign bus.o_pc4          = pc_q + SIZE_ADDR_PC'(4);
  assign bus.o_flush        = flush_q;
  assign bus.o_halted       = halted_q;
  assign bus.o_redirect_cnt = cnt_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed and randomized checks of pc_sequencer against a behavioural model.
module tb_pc_sequencer;
  localparam int N_DRAIN = 3;
  localparam int SIZE_CNT = 4;
  localparam int CNT_MAX = (1 << SIZE_CNT) - 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic step = 1'b1;
  int errors = 0;
  int checks = 0;
  int m_state;
  int m_left;
  int m_cnt;
  int halted_cycles;
  logic [31:0] m_pc;
  logic m_flush, m_halted;
  pc_sequencer_if #(.SIZE_ADDR_PC(32), .SIZE_CNT(SIZE_CNT)) bus ();
  pc_sequencer #(.SIZE_ADDR_PC(32), .RESET_PC(32'h0), .N_DRAIN(N_DRAIN), .SIZE_CNT(SIZE_CNT)) dut (
    .i_clk(clk),
    .i_reset(rst),
    .i_enable(en),
`ifdef PC_STEP_MODE_EN
    .i_step(step),
`endif
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic check_all();
    chk("pc", bus.o_pc, m_pc);
    chk("pc4", bus.o_pc4, m_pc + 32'd4);
    chk("flush", 32'(bus.o_flush), 32'(m_flush));
    chk("halted", 32'(bus.o_halted), 32'(m_halted));
    chk("cnt", 32'(bus.o_redirect_cnt), 32'(m_cnt));
  endtask
  task automatic model_reset();
    m_state = 0; m_pc = 0; m_flush = 0; m_halted = 0; m_cnt = 0; m_left = 0;
  endtask
  task automatic take(input logic [31:0] t);
    m_pc = t & ~32'h3;
    m_flush = 1;
    m_cnt = m_cnt < CNT_MAX ? m_cnt + 1 : CNT_MAX;
  endtask
  // Next state of the sequencer as the priority rules describe it, applied at one edge.
  task automatic model_edge();
    bit live;
`ifdef PC_STEP_MODE_EN
    live = en && step;
`else
    live = en;
`endif
    if (m_state == 0) begin
      if (en) m_state = 1;
    end else if (m_state == 1) begin
      m_flush = 0;
      if (live && !bus.i_stall) begin
        if (bus.i_halt) begin m_state = 2; m_left = N_DRAIN; end
        else if (bus.i_is_JALR) take(bus.i_rs);
        else if (bus.i_is_jump) take(bus.i_suma_jump);
        else if (bus.i_pc_source) take(bus.i_suma_branch);
        else m_pc = m_pc + 32'd4;
      end
    end else if (m_state == 2) begin
      m_left--;
      if (m_left == 0) begin m_state = 3; m_halted = 1; end
    end
  endtask
  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask
  task automatic clear();
    bus.i_stall = 0; bus.i_halt = 0; bus.i_is_jump = 0; bus.i_is_JALR = 0; bus.i_pc_source = 0;
    bus.i_rs = 0; bus.i_suma_branch = 0; bus.i_suma_jump = 0;
  endtask
  task automatic jump_to(input logic [31:0] t);
    clear(); bus.i_is_jump = 1; bus.i_suma_jump = t; cyc(); clear();
  endtask
  task automatic async_reset();
    #2 rst = 1;
    #1 model_reset();
    check_all();
    #1 rst = 0;
  endtask
  initial begin
    clear();
    model_reset();
    #2 check_all();
    #1 rst = 0;
    en = 1;
    for (int i = 0; i < 5; i++) cyc();
    chk("seq_pc16", bus.o_pc, 32'h10);
    bus.i_is_JALR = 1; bus.i_is_jump = 1; bus.i_pc_source = 1;
    bus.i_rs = 32'h43; bus.i_suma_jump = 32'h200; bus.i_suma_branch = 32'h80;
    cyc();
    chk("jalr_pc", bus.o_pc, 32'h40);
    chk("jalr_cnt", 32'(bus.o_redirect_cnt), 32'd1);
    bus.i_is_JALR = 0;
    cyc();
    chk("jump_pc", bus.o_pc, 32'h200);
    chk("jump_cnt", 32'(bus.o_redirect_cnt), 32'd2);
    clear();
    cyc();
    chk("flush_one_cycle", 32'(bus.o_flush), 32'd0);
    jump_to(32'h20);
    bus.i_stall = 1; bus.i_pc_source = 1; bus.i_suma_branch = 32'h80;
    cyc(); cyc();
    chk("stall_pc", bus.o_pc, 32'h20);
    bus.i_stall = 0;
    cyc();
    chk("branch_pc", bus.o_pc, 32'h80);
    en = 0;
    cyc(); cyc();
    en = 1;
    jump_to(32'hFFFF_FFFC);
    cyc();
    chk("wrap_pc", bus.o_pc, 32'h0);
`ifdef PC_STEP_MODE_EN
    for (int i = 0; i < 6; i++) begin
      step = (i == 1 || i == 4);
      cyc();
    end
    chk("step_pc", bus.o_pc, 32'h8);
    step = 1;
`endif
    jump_to(32'h30);
    bus.i_halt = 1; bus.i_is_jump = 1; bus.i_suma_jump = 32'h500;
    cyc();
    chk("halt_pc", bus.o_pc, 32'h30);
    clear();
    en = 0;
    cyc(); cyc();
    chk("halted_early", 32'(bus.o_halted), 32'd0);
    en = 1;
    cyc();
    chk("halted_rise", 32'(bus.o_halted), 32'd1);
    bus.i_pc_source = 1; bus.i_suma_branch = 32'h900;
    for (int i = 0; i < 4; i++) cyc();
    chk("halted_pc", bus.o_pc, 32'h30);
    async_reset();
    halted_cycles = 0;
    for (int i = 0; i < 600; i++) begin
      en = ($urandom % 8) != 0;
`ifdef PC_STEP_MODE_EN
      step = ($urandom % 4) != 0;
`endif
      bus.i_stall = ($urandom % 5) == 0;
      bus.i_halt = ($urandom % 60) == 0;
      bus.i_is_JALR = ($urandom % 4) == 0;
      bus.i_is_jump = ($urandom % 4) == 0;
      bus.i_pc_source = ($urandom % 4) == 0;
      bus.i_rs = $urandom;
      bus.i_suma_jump = $urandom;
      bus.i_suma_branch = $urandom;
      cyc();
      halted_cycles = m_state == 3 ? halted_cycles + 1 : 0;
      if (halted_cycles > 3) begin
        async_reset();
        halted_cycles = 0;
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the fetch-stage program counter register and sequences next-PC selection across four sources: pc+4, branch, jump and JALR.
- Arbitrates redirect requests from ID against hazard stalls and the HALT instruction, and issues the IF/ID flush.
- Drains the pipeline before reporting halt to the debug unit.
- Sits between the ID-stage control/hazard logic and the instruction memory address port.

Parameters:
- SIZE_ADDR_PC, 32, PC/address width.
- RESET_PC, 0, PC value loaded on reset.
- N_DRAIN, 3, cycles PC stays frozen after HALT before o_halted asserts (range 1..15).
- SIZE_CNT, 16, width of redirect counter.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_enable  in  1  run enable from debug unit; 0 freezes sequencing.
- i_stall  in  1  load-use hazard stall from ID.
- i_halt  in  1  HALT decoded in ID.
- i_is_jump  in  1  J/JAL in ID.
- i_is_JALR  in  1  JR/JALR in ID.
- i_pc_source  in  1  branch taken in ID.
- i_rs  in  SIZE_ADDR_PC  JALR/JR target.
- i_suma_branch  in  SIZE_ADDR_PC  branch target.
- i_suma_jump  in  SIZE_ADDR_PC  jump target.
- o_pc  out  SIZE_ADDR_PC  current PC to instruction memory.
- o_pc4  out  SIZE_ADDR_PC  o_pc+4, combinational.
- o_flush  out  1  registered flush of IF/ID, one cycle.
- o_halted  out  1  pipeline drained after HALT.
- o_redirect_cnt  out  SIZE_CNT  number of taken redirects.

Behaviour:
- Reset (async, any state): o_pc=RESET_PC, o_flush=0, o_halted=0, o_redirect_cnt=0, drain counter=0, state=IDLE.
- States: IDLE, RUN, DRAIN, HALTED.
- IDLE: PC held; go to RUN on the first cycle with i_enable=1. PC is not advanced on that edge, so the first fetch of RESET_PC lasts at least one RUN cycle.
- RUN, each edge with i_enable=1, resolved in priority order:
  - i_stall=1: PC held, o_flush=0. All redirects and i_halt are ignored, because the ID instruction is re-presented next cycle.
  - else i_halt=1: PC held, drain counter=N_DRAIN-1, go to DRAIN, o_flush=0. HALT beats any simultaneous redirect.
  - else i_is_JALR=1: PC={i_rs[SIZE_ADDR_PC-1:2],2'b00}.
  - else i_is_jump=1: PC=i_suma_jump with low 2 bits forced to 0.
  - else i_pc_source=1: PC=i_suma_branch with low 2 bits forced to 0.
  - else: PC=o_pc+4, wrapping modulo 2^SIZE_ADDR_PC (0xFFFFFFFC -> 0x00000000).
- Redirects (JALR/jump/branch): o_flush=1 for exactly the following cycle. o_redirect_cnt increments and saturates at all-ones.
- Non-redirect edges drive o_flush=0.
- RUN with i_enable=0: PC, flush (driven 0) and counter all held; state stays RUN.
- DRAIN: PC frozen regardless of inputs. Counter decrements on every edge, including edges with i_enable=0. When counter=0, go to HALTED.
- HALTED: o_halted=1, PC frozen. Only reset exits this state.
- Latency: selection is combinational on inputs; o_pc updates at the next rising edge.

Optional Feature:
- Macro: PC_STEP_MODE_EN.
- Defined: adds port i_step (in, 1). In RUN, PC update, redirects and halt detection occur only on edges where i_enable=1 and i_step=1. Otherwise the cycle behaves as i_enable=0. i_step held high steps every cycle. DRAIN and HALTED ignore i_step.
- Not defined: no i_step port; RUN advances on every enabled cycle.

Test Plan:
- Reset then i_enable=1, no requests, 5 cycles -> o_pc sequence 0,0,4,8,12,16; o_flush=0; counter=0.
- In RUN at o_pc=0x10, i_is_JALR=1, i_is_jump=1, i_pc_source=1, i_rs=0x43, i_suma_jump=0x200, i_suma_branch=0x80 -> next o_pc=0x40, o_flush=1 for one cycle, o_redirect_cnt=1. Repeat with only jump and branch -> 0x200, counter=2.
- i_stall=1 together with i_pc_source=1 at o_pc=0x20 -> o_pc stays 0x20, o_flush=0, counter unchanged. Release stall with branch still asserted -> o_pc=i_suma_branch.
- i_halt=1 with i_is_jump=1 at o_pc=0x30, N_DRAIN=3 -> o_pc stays 0x30 forever, o_flush=0, o_halted rises 3 cycles after the halt edge. Then i_reset pulse mid-HALTED -> o_pc=0, o_halted=0 immediately (asynchronous).
- o_pc=0xFFFFFFFC with no requests -> next o_pc=0x00000000.
- With PC_STEP_MODE_EN defined: i_step pulsed on 2 of 6 cycles -> o_pc advances exactly twice (0 -> 4 -> 8).
